// File: rtl/cp_read_unpacker_pkg.sv
// Shared CP constants used by the read unpacker and the write-gather path.
//   BYTES_PER_BEAT : bytes carried by one bus beat
//   BEAT_WIDTH     : bits in one bus beat
//   BYTE_IDX_W     : width of a byte index within a beat
package cp_read_unpacker_pkg;

  localparam int unsigned BYTES_PER_BEAT = 16;
  localparam int unsigned BEAT_WIDTH     = 128;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_BEAT);

endpackage

// File: rtl/cp_read_unpacker.sv
// Read unpacker: buffers up to BEATS 128-bit beats and streams them out one
// byte at a time, byte 0 first, beats in acceptance order.
// Ports:
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   flush         - discard all buffered data (control state only)
//   inValid/inReady/inData    - beat input handshake
//   outValid/outReady/outData - byte output handshake (outData is a pure mux)
//   level         - buffered bytes not yet consumed
//   underrun      - sticky: consumer was ready while no byte was valid
module cp_read_unpacker
  import cp_read_unpacker_pkg::*;
#(
  parameter int unsigned BEATS = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       flush,
  input  logic                                       inValid,
  input  logic [BEAT_WIDTH-1:0]                      inData,
  output logic                                       inReady,
  output logic                                       outValid,
  output logic [7:0]                                 outData,
  input  logic                                       outReady,
  output logic [$clog2(BEATS*BYTES_PER_BEAT):0]      level,
  output logic                                       underrun
);

  localparam int unsigned PTR_W   = $clog2(BEATS);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned LEVEL_W = $clog2(BEATS*BYTES_PER_BEAT) + 1;

  logic [BEAT_WIDTH-1:0] mem_q [BEATS];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic                  underrun_q, underrun_d;

  logic accept;
  logic consume;
  logic last_byte;
  logic head_free;

  // Handshake decode; a full buffer still accepts when the head slot frees this cycle.
  always_comb begin
    outValid  = (count_q != '0);
    last_byte = (byte_idx_q == BYTE_IDX_W'(BYTES_PER_BEAT - 1));
    consume   = outValid & outReady;
    head_free = consume & last_byte;
    inReady   = (count_q < CNT_W'(BEATS)) |
                ((count_q == CNT_W'(BEATS)) & head_free);
    accept    = inValid & inReady & ~flush;
  end

  // Current stream byte straight from the head slot.
  assign outData = mem_q[rd_ptr_q][{byte_idx_q, 3'b000} +: 8];

  assign level    = level_q;
  assign underrun = underrun_q;

  // Next-state logic; flush clears all control state and blocks a concurrent accept.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_idx_d = byte_idx_q;
    count_d    = count_q;
    level_d    = level_q;
    underrun_d = underrun_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      byte_idx_d = '0;
      count_d    = '0;
      level_d    = '0;
      underrun_d = 1'b0;
    end else begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(accept);
      rd_ptr_d   = rd_ptr_q + PTR_W'(head_free);
      // Index wraps 15->0 naturally in BYTE_IDX_W bits.
      byte_idx_d = byte_idx_q + BYTE_IDX_W'(consume);
      count_d    = count_q + CNT_W'(accept) - CNT_W'(head_free);
      level_d    = level_q + (accept ? LEVEL_W'(BYTES_PER_BEAT) : LEVEL_W'(0))
                           - LEVEL_W'(consume);
      underrun_d = underrun_q | (outReady & ~outValid);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_idx_q <= '0;
      count_q    <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_idx_q <= byte_idx_d;
      count_q    <= count_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
    end
  end

  // Beat storage keeps its contents across reset and flush.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem_q[wr_ptr_q] <= inData;
    end
  end

endmodule

// File: tb/tb_cp_read_unpacker.sv
// Self-checking bench for cp_read_unpacker (BEATS=2): a directed vector table
// followed by hand-written multi-cycle sequences.
module tb_cp_read_unpacker;

  localparam int unsigned BEATS = 2;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         inValid;
  logic [127:0] inData;
  logic         inReady;
  logic         outValid;
  logic [7:0]   outData;
  logic         outReady;
  logic [5:0]   level;
  logic         underrun;

  int checks   = 0;
  int failures = 0;

  cp_read_unpacker #(.BEATS(BEATS)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .inValid  (inValid),
    .inData   (inData),
    .inReady  (inReady),
    .outValid (outValid),
    .outData  (outData),
    .outReady (outReady),
    .level    (level),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [7:0]  base;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [31:0] e_lvl;
    logic        e_ur;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [127:0] mk_beat(input logic [7:0] base);
    logic [127:0] b;
    for (int k = 0; k < 16; k++) b[8*k +: 8] = base + 8'(k);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then settle before sampling.
  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [7:0] base, input logic ordy);
    @(negedge clk);
    reset    = r;
    flush    = f;
    inValid  = iv;
    inData   = mk_beat(base);
    outReady = ordy;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] q [$];
    int next_beat;
    int cyc;
    int got;
    int mbeats;
    logic iv_r;
    logic ordy_r;
    logic exp_irdy;

    reset = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;

    //          rst  fl   iv   base   ordy  irdy ov   od     lvl ur
    tbl[0]  = '{1'b0,1'b0,1'b1,8'h00,1'b0, 1'b1,1'b0,8'h00, 0, 1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b1,8'h10,1'b0, 1'b1,1'b1,8'h00, 16,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b1,8'h20,1'b0, 1'b0,1'b1,8'h00, 32,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b1,8'h00, 32,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b1,8'h01, 31,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b1,8'h40,1'b0, 1'b0,1'b1,8'h02, 30,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b0,8'h00, 0, 1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00, 0, 1'b1};
    tbl[8]  = '{1'b0,1'b0,1'b1,8'h50,1'b0, 1'b1,1'b0,8'h00, 0, 1'b1};
    tbl[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h50, 16,1'b1};
    tbl[10] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h51, 15,1'b1};
    tbl[11] = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00, 0, 1'b0};
    tbl[12] = '{1'b0,1'b0,1'b1,8'h60,1'b0, 1'b1,1'b0,8'h00, 0, 1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h60, 16,1'b0};

    // Directed table: outputs checked against state built by earlier rows.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].base, tbl[i].ordy);
      chk($sformatf("t%0d_inReady", i),  32'(inReady),  32'(tbl[i].e_irdy));
      chk($sformatf("t%0d_outValid", i), 32'(outValid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("t%0d_outData", i), 32'(outData), 32'(tbl[i].e_od));
      chk($sformatf("t%0d_level", i),    32'(level),    tbl[i].e_lvl);
      chk($sformatf("t%0d_underrun", i), 32'(underrun), 32'(tbl[i].e_ur));
    end

    // Single beat streamed with outReady held high.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    chk("s1_empty_ov", 32'(outValid), 32'd0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk($sformatf("s1_ov_%0d", k), 32'(outValid), 32'd1);
      chk($sformatf("s1_od_%0d", k), 32'(outData), 32'(k));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("s1_drained_ov", 32'(outValid), 32'd0);
    chk("s1_drained_lvl", 32'(level), 32'd0);

    // Full buffer: third beat waits for the last byte of the head beat.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h20, 1'b0);
    chk("s2_full_irdy", 32'(inReady), 32'd0);
    chk("s2_full_lvl", 32'(level), 32'd32);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, 1'b1, 8'h20, 1'b1);
      chk($sformatf("s2_irdy_%0d", k), 32'(inReady), 32'(k == 15));
      chk($sformatf("s2_od_%0d", k), 32'(outData), 32'(k));
    end
    for (int j = 0; j < 32; j++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      if (j == 0) chk("s2_lvl_after_swap", 32'(level), 32'd32);
      chk($sformatf("s2_drain_od_%0d", j), 32'(outData), 32'(8'h10 + 8'(j)));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("s2_empty_ov", 32'(outValid), 32'd0);

    // Random consumer stalls against a byte-queue reference.
    do_reset();
    next_beat = 0;
    cyc = 0;
    got = 0;
    while ((next_beat < 8 || q.size() != 0) && cyc < 3000) begin
      iv_r   = (next_beat < 8);
      ordy_r = ($urandom_range(0, 3) != 0);
      drive(1'b0, 1'b0, iv_r, 8'(next_beat * 16), ordy_r);
      mbeats   = (q.size() + 15) / 16;
      exp_irdy = (mbeats < 2) || (mbeats == 2 && ordy_r && (q.size() % 16) == 1);
      chk("s3_irdy", 32'(inReady), 32'(exp_irdy));
      chk("s3_ov", 32'(outValid), 32'(q.size() != 0));
      chk("s3_lvl", 32'(level), 32'(q.size()));
      if (q.size() != 0) chk("s3_od", 32'(outData), 32'(q[0]));
      if (outValid && ordy_r) begin
        void'(q.pop_front());
        got++;
      end
      if (iv_r && inReady) begin
        for (int k = 0; k < 16; k++) q.push_back(8'(next_beat * 16 + k));
        next_beat++;
      end
      cyc++;
    end
    chk("s3_remaining", 32'(q.size() + (8 - next_beat)), 32'd0);
    chk("s3_bytes", 32'(got), 32'd128);

    // Flush after five bytes, with a beat offered in the same cycle.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 8'h80, 1'b0);
    chk("s4_pre_flush_od", 32'(outData), 32'h05);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("s4_lvl", 32'(level), 32'd0);
    chk("s4_ov", 32'(outValid), 32'd0);
    chk("s4_irdy", 32'(inReady), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 8'hC0, 1'b0);
    chk("s4_not_stored_ov", 32'(outValid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("s4_fresh_od", 32'(outData), 32'hC0);
    chk("s4_fresh_lvl", 32'(level), 32'd16);

    // Reset mid-beat at byte 7 of beat 1.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h10, 1'b1);
    for (int k = 0; k < 22; k++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("s5_pre_reset_od", 32'(outData), 32'h17);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("s5_ov", 32'(outValid), 32'd0);
    chk("s5_lvl", 32'(level), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 8'hE0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("s5_fresh_od0", 32'(outData), 32'hE0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("s5_fresh_od1", 32'(outData), 32'hE1);
    chk("s5_fresh_lvl", 32'(level), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp_read_unpacker.md
CP_READ_UNPACKER -- requirements
Module: cp_read_unpacker

Interface
REQ-001 SHALL have parameter BEATS, default 2, giving the number of 128-bit beat slots buffered; legal values are powers of two >= 2.
REQ-002 SHALL have port clk  input  1  sole clock; all logic is on the rising edge.
REQ-003 SHALL have port reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port flush  input  1  discards all buffered data.
REQ-005 SHALL have port inValid  input  1  a 128-bit beat is offered.
REQ-006 SHALL have port inData  input  128  offered beat; byte k is inData[8k+7:8k].
REQ-007 SHALL have port inReady  output  1  the block can accept a beat this cycle.
REQ-008 SHALL have port outValid  output  1  outData holds a valid byte.
REQ-009 SHALL have port outData  output  8  current stream byte.
REQ-010 SHALL have port outReady  input  1  the consumer takes outData this cycle.
REQ-011 SHALL have port level  output  $clog2(BEATS*16)+1  number of buffered bytes not yet consumed.
REQ-012 SHALL have port underrun  output  1  sticky flag: outReady was high while outValid was low.

Function
REQ-013 SHALL accept a beat when inValid & inReady, writing it into the slot addressed by the write pointer and advancing that pointer modulo BEATS.
REQ-014 SHALL drive inReady = (beat count < BEATS) | (beat count == BEATS & the final byte of the head beat is being consumed this cycle).
REQ-015 SHALL present bytes in order byte 0 through byte 15 of each beat, then continue with the next beat in acceptance order.
REQ-016 SHALL drive outData combinationally from the head slot selected by a 4-bit byte index, with no other logic on the path.
REQ-017 SHALL make the first byte of a beat accepted into an empty buffer visible at outValid in the next cycle, giving a latency of 1 cycle.
REQ-018 SHALL advance the byte index on outValid & outReady; on a 15->0 wrap it SHALL advance the read pointer modulo BEATS and free the slot.
REQ-019 SHALL drive outValid = (beat count != 0).
REQ-020 SHALL support a beat accept and a byte consume in the same cycle, leaving the beat count unchanged when the consume also frees a slot.
REQ-021 SHALL update level each cycle as level + 16*accept - consume, registered, so that level equals 16*beats - byteIndex.
REQ-022 SHALL set underrun when outReady & ~outValid, and clear it only on reset or flush.
REQ-023 SHALL, on flush, zero both pointers, the byte index, the beat count, level and underrun, and ignore any beat offered in the same cycle; flush takes priority over all other events.
REQ-024 SHALL keep stored beat data unchanged by reset or flush; only the control state is cleared.

Reset
REQ-025 SHALL, while reset is high, drive inReady=1 (from the next cycle), outValid=0, level=0, underrun=0, and zero both pointers and the byte index.
REQ-026 SHALL let reset asserted mid-beat discard the partial beat, with no byte of it emitted after reset.
REQ-027 SHALL give reset priority over flush and over all handshakes.

Structure
REQ-028 SHALL take constants BYTES_PER_BEAT=16 and BEAT_WIDTH=128 from the shared CP package, which the write-gather path also uses.
REQ-029 SHALL be a single module with no sub-modules; beat storage is a BEATS x 128 register array.

Verification
REQ-030 SHALL cover: after reset, one beat 0x0F0E...0100 with outReady=1 -> outData 0x00,0x01,...,0x0F on 16 consecutive cycles starting 1 cycle after accept, then outValid=0.
REQ-031 SHALL cover: two beats accepted back-to-back with outReady=0 -> inReady=0, level=32; a third beat is held until the 16th byte is consumed, and is accepted on that same cycle.
REQ-032 SHALL cover: random outReady stalls over 8 beats of 0x00..0x7F -> the output sequence is 0x00..0x7F exactly, with level matching a reference count every cycle.
REQ-033 SHALL cover: outReady=1 with an empty buffer -> underrun=1, held until flush, after which underrun=0.
REQ-034 SHALL cover: flush asserted after 5 bytes of beat 0, concurrent with inValid -> the next cycle shows level=0, outValid=0, and the concurrent beat is not stored.
REQ-035 SHALL cover: reset pulsed at byte 7 of beat 1 -> outValid=0 and level=0 on the next cycle, and a fresh beat restarts at byte 0.
